// File: rtl/rf_pkg.sv
// Shared types for the register-file writeback arbiter and its result buffer.
package rf_pkg;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   wd;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Ordered buffer of long-latency results with per-entry invalidate and rd compare.
// Survivors are re-packed behind the head every cycle, so the buffer never holds holes.
module wb_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enq,
  input  logic [REG_AW-1:0]        enq_rd,
  input  logic [XLEN-1:0]          enq_wd,
  input  logic                     deq,
  input  logic                     inval,
  input  logic [REG_AW-1:0]        inval_rd,
  input  logic [REG_AW-1:0]        cmp_a1,
  input  logic [REG_AW-1:0]        cmp_a2,
  output wb_entry_t                head,
  output logic [$clog2(DEPTH):0]   cnt,
  output logic [DEPTH-1:0]         hit_a1,
  output logic [DEPTH-1:0]         hit_a2
);
  localparam int PW = $clog2(DEPTH);
  typedef logic [PW-1:0] ptr_t;
  typedef logic [PW:0]   cnt_t;

  wb_entry_t        mem     [DEPTH];
  wb_entry_t        mem_nxt [DEPTH];
  ptr_t             head_q;
  ptr_t             head_nxt;
  cnt_t             cnt_q;
  cnt_t             cnt_nxt;
  logic [DEPTH-1:0] kill;

  assign head = mem[head_q];
  assign cnt  = cnt_q;

  always_comb begin
    kill   = '0;
    hit_a1 = '0;
    hit_a2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      kill[i]   = inval && mem[i].valid && (mem[i].rd == inval_rd);
      hit_a1[i] = mem[i].valid && (mem[i].rd == cmp_a1);
      hit_a2[i] = mem[i].valid && (mem[i].rd == cmp_a2);
    end
  end

  // Walk entries oldest-first from the head and copy the survivors contiguously
  // behind the new head; the new result lands right after the last survivor.
  always_comb begin
    cnt_t kept;
    ptr_t slot;
    kept     = '0;
    slot     = '0;
    head_nxt = head_q + ptr_t'(deq);
    for (int i = 0; i < DEPTH; i++) mem_nxt[i] = '0;
    for (int j = 0; j < DEPTH; j++) begin
      slot = head_q + ptr_t'(j);
      if ((cnt_t'(j) < cnt_q) && !(deq && (j == 0)) && !kill[slot]) begin
        mem_nxt[head_nxt + kept[PW-1:0]] = mem[slot];
        kept = kept + 1'b1;
      end
    end
    if (enq) mem_nxt[head_nxt + kept[PW-1:0]] = '{valid: 1'b1, rd: enq_rd, wd: enq_wd};
    cnt_nxt = kept + cnt_t'(enq);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      head_q <= head_nxt;
      cnt_q  <= cnt_nxt;
      for (int i = 0; i < DEPTH; i++) mem[i] <= mem_nxt[i];
    end
  end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between the pipeline (absolute priority)
// and buffered long-latency results; flags decode sources that hit the buffer.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   pipe_we,
  input  logic [REG_AW-1:0]      pipe_rd,
  input  logic [XLEN-1:0]        pipe_wd,
  input  logic                   lu_valid,
  input  logic [REG_AW-1:0]      lu_rd,
  input  logic [XLEN-1:0]        lu_wd,
  output logic                   lu_ready,
  output logic                   rf_we3,
  output logic [REG_AW-1:0]      rf_a3,
  output logic [XLEN-1:0]        rf_wd3,
  input  logic [REG_AW-1:0]      a1,
  input  logic [REG_AW-1:0]      a2,
  output logic                   hz_stall,
  output logic [$clog2(DEPTH):0] pend_cnt
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  wb_entry_t        head;
  logic [CW-1:0]    cnt;
  logic [DEPTH-1:0] hit_a1;
  logic [DEPTH-1:0] hit_a2;
  logic             enq;
  logic             deq;
  logic             inval;

  // LU handshake: a result transfers on a posedge with lu_valid && lu_ready;
  // lu_ready depends only on the registered count, and rd=0 results are dropped.
  assign lu_ready = reset_n && (cnt < FULL);
  assign enq      = lu_valid && lu_ready && (lu_rd != '0);
  assign deq      = reset_n && !pipe_we && head.valid;
  assign inval    = reset_n && pipe_we && (pipe_rd != '0);
  assign hz_stall = reset_n && (((a1 != '0) && (|hit_a1)) || ((a2 != '0) && (|hit_a2)));
  assign pend_cnt = reset_n ? cnt : '0;

  always_comb begin
    rf_we3 = 1'b0;
    rf_a3  = '0;
    rf_wd3 = '0;
    if (reset_n) begin
      if (pipe_we) begin
        rf_we3 = (pipe_rd != '0);
        rf_a3  = pipe_rd;
        rf_wd3 = pipe_wd;
      end else if (head.valid) begin
        rf_we3 = 1'b1;
        rf_a3  = head.rd;
        rf_wd3 = head.wd;
      end
    end
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .enq      (enq),
    .enq_rd   (lu_rd),
    .enq_wd   (lu_wd),
    .deq      (deq),
    .inval    (inval),
    .inval_rd (pipe_rd),
    .cmp_a1   (a1),
    .cmp_a2   (a2),
    .head     (head),
    .cnt      (cnt),
    .hit_a1   (hit_a1),
    .hit_a2   (hit_a2)
  );
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_rf_wb_arbiter;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          pipe_we;
  logic [4:0]    pipe_rd;
  logic [31:0]   pipe_wd;
  logic          lu_valid;
  logic [4:0]    lu_rd;
  logic [31:0]   lu_wd;
  logic          lu_ready;
  logic          rf_we3;
  logic [4:0]    rf_a3;
  logic [31:0]   rf_wd3;
  logic [4:0]    a1;
  logic [4:0]    a2;
  logic          hz_stall;
  logic [CW-1:0] pend_cnt;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .pipe_we  (pipe_we),
    .pipe_rd  (pipe_rd),
    .pipe_wd  (pipe_wd),
    .lu_valid (lu_valid),
    .lu_rd    (lu_rd),
    .lu_wd    (lu_wd),
    .lu_ready (lu_ready),
    .rf_we3   (rf_we3),
    .rf_a3    (rf_a3),
    .rf_wd3   (rf_wd3),
    .a1       (a1),
    .a2       (a2),
    .hz_stall (hz_stall),
    .pend_cnt (pend_cnt)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] wd;
  } ent_t;

  ent_t mq[$];
  int   checks   = 0;
  int   errors   = 0;
  bit   check_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model update: buffer is an age-ordered list of pending results.
  always @(posedge clk) begin
    if (!reset_n) begin
      mq.delete();
    end else begin
      bit take;
      take = lu_valid && (mq.size() < DEPTH);
      if (pipe_we && (pipe_rd != 5'd0)) begin
        for (int i = mq.size() - 1; i >= 0; i--)
          if (mq[i].rd == pipe_rd) mq.delete(i);
      end else if (!pipe_we && (mq.size() > 0)) begin
        void'(mq.pop_front());
      end
      if (take && (lu_rd != 5'd0)) mq.push_back('{lu_rd, lu_wd});
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      logic        e_we;
      logic [4:0]  e_a3;
      logic [31:0] e_wd;
      logic        e_rdy;
      logic        e_hz;
      int          e_cnt;
      e_we = 1'b0; e_a3 = '0; e_wd = '0; e_rdy = 1'b0; e_hz = 1'b0; e_cnt = 0;
      if (reset_n) begin
        e_rdy = (mq.size() < DEPTH);
        e_cnt = mq.size();
        if (pipe_we) begin
          e_we = (pipe_rd != 5'd0);
          e_a3 = pipe_rd;
          e_wd = pipe_wd;
        end else if (mq.size() > 0) begin
          e_we = 1'b1;
          e_a3 = mq[0].rd;
          e_wd = mq[0].wd;
        end
        foreach (mq[i])
          if (((a1 != 5'd0) && (mq[i].rd == a1)) || ((a2 != 5'd0) && (mq[i].rd == a2))) e_hz = 1'b1;
      end
      check("m_rf_we3", 32'(rf_we3), 32'(e_we));
      check("m_rf_a3", 32'(rf_a3), 32'(e_a3));
      check("m_rf_wd3", rf_wd3, e_wd);
      check("m_lu_ready", 32'(lu_ready), 32'(e_rdy));
      check("m_hz_stall", 32'(hz_stall), 32'(e_hz));
      check("m_pend_cnt", 32'(pend_cnt), 32'(e_cnt));
    end
  end

  // Apply one cycle of inputs just after the posedge, return at the negedge.
  task automatic drive(input logic rst, input logic pw, input logic [4:0] prd, input logic [31:0] pwd,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] lwd,
                       input logic [4:0] s1, input logic [4:0] s2);
    @(posedge clk);
    #1;
    reset_n = rst; pipe_we = pw; pipe_rd = prd; pipe_wd = pwd;
    lu_valid = lv; lu_rd = lrd; lu_wd = lwd; a1 = s1; a2 = s2;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset_n = 1'b0; pipe_we = 1'b0; pipe_rd = '0; pipe_wd = '0;
    lu_valid = 1'b0; lu_rd = '0; lu_wd = '0; a1 = '0; a2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check_en = 1'b1;

    // Reset holds outputs low even with active inputs.
    drive(0, 1, 5'd3, 32'h55, 1, 5'd4, 32'h66, 5'd4, 5'd3);
    check("rst_we", 32'(rf_we3), 0);
    check("rst_ready", 32'(lu_ready), 0);
    check("rst_pend", 32'(pend_cnt), 0);
    check("rst_hz", 32'(hz_stall), 0);

    // LU result rd=5 written in the following cycle.
    drive(1, 0, 0, 0, 1, 5'd5, 32'hDEAD, 0, 0);
    check("lu_first_ready", 32'(lu_ready), 1);
    idle();
    check("lu_we", 32'(rf_we3), 1);
    check("lu_a3", 32'(rf_a3), 5);
    check("lu_wd3", rf_wd3, 32'hDEAD);
    idle();
    check("lu_drained", 32'(pend_cnt), 0);
    check("lu_drained_we", 32'(rf_we3), 0);

    // Two results buffered behind a busy pipeline, drained oldest first.
    drive(1, 1, 5'd1, 32'h11, 1, 5'd10, 32'hA, 0, 0);
    drive(1, 1, 5'd1, 32'h12, 1, 5'd11, 32'hB, 0, 0);
    check("full_pend1", 32'(pend_cnt), 1);
    drive(1, 1, 5'd1, 32'h13, 0, 0, 0, 0, 0);
    check("full_ready", 32'(lu_ready), 0);
    check("full_pend2", 32'(pend_cnt), 2);
    check("full_pipe_a3", 32'(rf_a3), 1);
    idle();
    check("drain1_a3", 32'(rf_a3), 10);
    check("drain1_wd", rf_wd3, 32'hA);
    idle();
    check("drain2_a3", 32'(rf_a3), 11);
    check("drain2_wd", rf_wd3, 32'hB);
    idle();

    // Hazard on buffered rd=7.
    drive(1, 1, 5'd1, 32'h1, 1, 5'd7, 32'h77, 0, 0);
    drive(1, 1, 5'd1, 32'h1, 0, 0, 0, 5'd7, 0);
    check("hz_a1", 32'(hz_stall), 1);
    drive(1, 1, 5'd1, 32'h1, 0, 0, 0, 0, 0);
    check("hz_zero", 32'(hz_stall), 0);
    drive(1, 1, 5'd1, 32'h1, 0, 0, 0, 0, 5'd7);
    check("hz_a2", 32'(hz_stall), 1);
    idle();
    check("hz_drain_a3", 32'(rf_a3), 7);
    idle();

    // Pipeline write to x9 supersedes the buffered x9 result.
    drive(1, 1, 5'd1, 32'h1, 1, 5'd9, 32'h99, 0, 0);
    drive(1, 1, 5'd9, 32'h1, 0, 0, 0, 0, 0);
    check("waw_pend", 32'(pend_cnt), 1);
    check("waw_wd", rf_wd3, 32'h1);
    idle();
    check("waw_gone_pend", 32'(pend_cnt), 0);
    check("waw_no_write", 32'(rf_we3), 0);
    idle();
    check("waw_no_write2", 32'(rf_we3), 0);

    // rd=0 result is accepted and discarded.
    drive(1, 0, 0, 0, 1, 5'd0, 32'h5, 0, 0);
    check("rd0_ready", 32'(lu_ready), 1);
    idle();
    check("rd0_pend", 32'(pend_cnt), 0);
    check("rd0_we", 32'(rf_we3), 0);

    // Reset with two entries buffered.
    drive(1, 1, 5'd1, 32'h1, 1, 5'd3, 32'h33, 0, 0);
    drive(1, 1, 5'd1, 32'h1, 1, 5'd4, 32'h44, 0, 0);
    drive(1, 1, 5'd1, 32'h1, 0, 0, 0, 0, 0);
    check("pre_rst_pend", 32'(pend_cnt), 2);
    drive(0, 0, 0, 0, 1, 5'd6, 32'h66, 5'd3, 0);
    check("mid_rst_we", 32'(rf_we3), 0);
    check("mid_rst_pend", 32'(pend_cnt), 0);
    idle();
    check("post_rst_pend", 32'(pend_cnt), 0);
    check("post_rst_we", 32'(rf_we3), 0);
    idle();
    check("post_rst_we2", 32'(rf_we3), 0);

    // Randomized traffic on a small register range to force collisions.
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 99) != 0), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    repeat (4) idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
